// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter states, mouse command bytes, parity helper, timing defaults.
package ps2_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_INHIBIT,
      ST_RTS,
      ST_SHIFT,
      ST_STOP,
      ST_ACK,
      ST_WAIT_IDLE
   } ps2_state_t;

   localparam logic [7:0] CMD_RESET    = 8'hFF;
   localparam logic [7:0] CMD_ENABLE   = 8'hF4;
   localparam logic [7:0] CMD_DEFAULTS = 8'hF6;

   localparam int INHIBIT_CYCLES_DEF = 5000;
   localparam int TIMEOUT_CYCLES_DEF = 750000;

   function automatic logic odd_parity(input logic [7:0] d);
      return ~^d;
   endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command handshake between a requester (master) and the PS/2 transmitter (slave).
interface ps2_host_tx_if;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       tx_done;
   logic       tx_error;
   logic       busy;

   modport master (output tx_data, tx_valid, input tx_ready, tx_done, tx_error, busy);
   modport slave  (input tx_data, tx_valid, output tx_ready, tx_done, tx_error, busy);
endinterface

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizers for PS2_CLK/PS2_DAT plus a registered falling-edge strobe.
module ps2_line_sync (
   input  logic CLOCK_50,
   input  logic reset,
   input  logic clk_raw,
   input  logic dat_raw,
   output logic clk_sync,
   output logic dat_sync,
   output logic fall
);
   logic clk_meta;
   logic dat_meta;

   // Idle lines are high, so reset to 1 to avoid a spurious edge on release.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         clk_meta <= 1'b1;
         clk_sync <= 1'b1;
         dat_meta <= 1'b1;
         dat_sync <= 1'b1;
         fall     <= 1'b0;
      end else begin
         clk_meta <= clk_raw;
         clk_sync <= clk_meta;
         dat_meta <= dat_raw;
         dat_sync <= dat_meta;
         fall     <= clk_sync & ~clk_meta;
      end
   end
endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, data/parity/stop, then ACK check.
// Define PS2_TX_AUTOINIT_EN to send CMD_ENABLE automatically after reset (up to 3 attempts).
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int INHIBIT_CYCLES = INHIBIT_CYCLES_DEF,
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
   input  logic         CLOCK_50,
   input  logic         reset,
   ps2_host_tx_if.slave tx,
   input  logic         ps2_clk_in,
   input  logic         ps2_dat_in,
   output logic         ps2_clk_oe,
   output logic         ps2_dat_oe
);
`ifdef PS2_TX_AUTOINIT_EN
   localparam bit AUTO_INIT = 1'b1;
`else
   localparam bit AUTO_INIT = 1'b0;
`endif

   localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   ps2_state_t       state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic [2:0]       bit_cnt, bit_cnt_n;
   logic [8:0]       shreg, shreg_n;
   logic [1:0]       attempts, attempts_n;
   logic             ready_r, ready_n, done_r, done_n, error_r, error_n, busy_r, busy_n;
   logic             clk_oe_n, dat_oe_n, auto_pend, auto_pend_n;
   logic             load, end_ok, end_err;
   logic [7:0]       load_byte;
   logic             clk_s, dat_s, fall;

   ps2_line_sync u_sync (
      .CLOCK_50 (CLOCK_50),
      .reset    (reset),
      .clk_raw  (ps2_clk_in),
      .dat_raw  (ps2_dat_in),
      .clk_sync (clk_s),
      .dat_sync (dat_s),
      .fall     (fall)
   );

   assign tx.tx_ready = ready_r;
   assign tx.tx_done  = done_r;
   assign tx.tx_error = error_r;
   assign tx.busy     = busy_r;

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state      <= ST_IDLE;
         cnt        <= '0;
         bit_cnt    <= '0;
         attempts   <= '0;
         auto_pend  <= AUTO_INIT;
         ready_r    <= 1'b0;
         done_r     <= 1'b0;
         error_r    <= 1'b0;
         busy_r     <= 1'b0;
         ps2_clk_oe <= 1'b0;
         ps2_dat_oe <= 1'b0;
      end else begin
         state      <= state_n;
         cnt        <= cnt_n;
         bit_cnt    <= bit_cnt_n;
         attempts   <= attempts_n;
         auto_pend  <= auto_pend_n;
         ready_r    <= ready_n;
         done_r     <= done_n;
         error_r    <= error_n;
         busy_r     <= busy_n;
         ps2_clk_oe <= clk_oe_n;
         ps2_dat_oe <= dat_oe_n;
      end
   end

   always_ff @(posedge CLOCK_50) begin
      shreg <= shreg_n;
   end

   always_comb begin
      state_n     = state;
      cnt_n       = cnt;
      bit_cnt_n   = bit_cnt;
      shreg_n     = shreg;
      attempts_n  = attempts;
      auto_pend_n = auto_pend;
      ready_n     = 1'b0;
      done_n      = 1'b0;
      error_n     = 1'b0;
      busy_n      = busy_r;
      clk_oe_n    = ps2_clk_oe;
      dat_oe_n    = ps2_dat_oe;
      load        = 1'b0;
      load_byte   = tx.tx_data;
      end_ok      = 1'b0;
      end_err     = 1'b0;

      case (state)
         ST_IDLE: begin
            ready_n = !auto_pend;
            if (auto_pend) begin
               load      = 1'b1;
               load_byte = CMD_ENABLE;
            end else if (tx.tx_valid && ready_r) begin
               load = 1'b1;
            end
            if (load) begin
               state_n   = ST_INHIBIT;
               shreg_n   = {odd_parity(load_byte), load_byte};
               bit_cnt_n = '0;
               cnt_n     = '0;
               clk_oe_n  = 1'b1;
               busy_n    = 1'b1;
               ready_n   = 1'b0;
            end
         end
         ST_INHIBIT: begin
            if (cnt == INH_LAST) begin
               state_n  = ST_RTS;
               clk_oe_n = 1'b0;
               dat_oe_n = 1'b1;
               cnt_n    = '0;
            end else begin
               cnt_n = cnt + CNT_W'(1);
            end
         end
         default: begin
            // Device-clocked states share one watchdog that restarts on every falling edge.
            cnt_n = fall ? '0 : cnt + CNT_W'(1);
            if (!fall && cnt == TMO_LAST) begin
               end_err = 1'b1;
            end else if (state == ST_WAIT_IDLE) begin
               end_ok = clk_s & dat_s;
            end else if (fall) begin
               case (state)
                  ST_RTS, ST_SHIFT: begin
                     dat_oe_n = ~shreg[0];
                     shreg_n  = {1'b0, shreg[8:1]};
                     if (state == ST_RTS) begin
                        state_n = ST_SHIFT;
                     end else if (bit_cnt == 3'd7) begin
                        state_n = ST_STOP;
                     end else begin
                        bit_cnt_n = bit_cnt + 3'd1;
                     end
                  end
                  ST_STOP: begin
                     dat_oe_n = 1'b0;
                     state_n  = ST_ACK;
                  end
                  ST_ACK: begin
                     if (dat_s) end_err = 1'b1;
                     else       state_n = ST_WAIT_IDLE;
                  end
                  default: ;
               endcase
            end
         end
      endcase

      if (end_ok || end_err) begin
         state_n  = ST_IDLE;
         busy_n   = 1'b0;
         clk_oe_n = 1'b0;
         dat_oe_n = 1'b0;
         done_n   = end_ok;
         error_n  = end_err;
         // An automatic frame is retried on failure until its third attempt.
         if (auto_pend) begin
            if (end_err && attempts != 2'd2) attempts_n  = attempts + 2'd1;
            else                             auto_pend_n = 1'b0;
         end
         ready_n = !auto_pend_n;
      end
   end
endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model clocks frames out of the host and a reference model checks them.
module tb_ps2_host_tx;
   import ps2_pkg::*;

   localparam int INH  = 1000;
   localparam int TMO  = 1500;
   localparam int HALF = 100;
`ifdef PS2_TX_AUTOINIT_EN
   localparam bit AUTO = 1'b1;
`else
   localparam bit AUTO = 1'b0;
`endif

   logic       CLOCK_50 = 1'b0;
   logic       reset = 1'b1;
   logic       dev_clk_low = 1'b0;
   logic       dev_dat_low = 1'b0;
   logic       ps2_clk_oe, ps2_dat_oe;
   logic       pin_clk, pin_dat;
   int         n_checks = 0;
   int         n_errors = 0;
   int         done_cnt = 0, err_cnt = 0, overlap = 0, wide = 0;
   logic       prev_done = 1'b0;
   logic [3:0] err_snap = '0;

   ps2_host_tx_if tx();

   assign pin_clk = !(ps2_clk_oe || dev_clk_low);
   assign pin_dat = !(ps2_dat_oe || dev_dat_low);

   ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
      .CLOCK_50   (CLOCK_50),
      .reset      (reset),
      .tx         (tx),
      .ps2_clk_in (pin_clk),
      .ps2_dat_in (pin_dat),
      .ps2_clk_oe (ps2_clk_oe),
      .ps2_dat_oe (ps2_dat_oe)
   );

   always #10 CLOCK_50 = ~CLOCK_50;

   initial begin
      #2400000;
      $display("FAIL watchdog: simulation exceeded its time limit");
      $fatal(1, "watchdog");
   end

   always @(negedge CLOCK_50) begin
      if (tx.tx_done) done_cnt++;
      if (tx.tx_error) begin
         err_cnt++;
         err_snap = {ps2_clk_oe, ps2_dat_oe, tx.busy, tx.tx_done};
      end
      if (tx.tx_done && tx.tx_error) overlap++;
      if (tx.tx_done && prev_done) wide++;
      prev_done = tx.tx_done;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference frame as the device sees it: {stop, parity, data}; parity makes the 9-bit ones count odd.
   function automatic logic [9:0] model_frame(input logic [7:0] b);
      int ones = $countones(b);
      return {1'b1, ((ones % 2) == 0), b};
   endfunction

   task automatic start_byte(input logic [7:0] b);
      int w = 0;
      while (!tx.tx_ready && w < 20000) begin
         @(negedge CLOCK_50);
         w++;
      end
      check("ready_wait", 32'(tx.tx_ready), 32'd1);
      tx.tx_data  = b;
      tx.tx_valid = 1'b1;
      @(posedge CLOCK_50);
      #1 tx.tx_valid = 1'b0;
      @(negedge CLOCK_50);
      check("busy_accept", 32'({tx.busy, tx.tx_ready}), 32'd2);
   endtask

   task automatic run_frame(input logic [7:0] b, input bit ack, input bit chk_inh,
                            input bit exp_ready, input int abort_at, input bit mid_valid);
      int         n;
      int         d0, e0;
      logic [9:0] cap;
      bit         aborted;
      d0 = done_cnt;
      e0 = err_cnt;
      cap = '0;
      aborted = 1'b0;
      n = 0;
      while (!ps2_clk_oe && n < INH + TMO) begin
         @(negedge CLOCK_50);
         n++;
      end
      n = 0;
      while (ps2_clk_oe && n < INH + 100) begin
         n++;
         @(negedge CLOCK_50);
      end
      if (chk_inh) check("inhibit_len", 32'(n), 32'(INH));
      check("start_bit", 32'({ps2_dat_oe, pin_dat}), 32'd2);
      repeat (50) @(negedge CLOCK_50);
      for (int i = 1; i <= 11; i++) begin
         dev_clk_low = 1'b1;
         if (i == abort_at) begin
            repeat (HALF / 2) @(negedge CLOCK_50);
            reset = 1'b1;
            @(posedge CLOCK_50);
            #1;
            check("rst_mid", 32'({ps2_clk_oe, ps2_dat_oe, tx.busy, tx.tx_done, tx.tx_error}), 32'd0);
            dev_clk_low = 1'b0;
            @(negedge CLOCK_50);
            reset = 1'b0;
            @(posedge CLOCK_50);
            #1;
            check("rst_ready", 32'(tx.tx_ready), 32'(!AUTO));
            aborted = 1'b1;
            break;
         end
         if (mid_valid && i == 3) begin
            @(negedge CLOCK_50);
            tx.tx_data  = 8'h5A;
            tx.tx_valid = 1'b1;
            @(negedge CLOCK_50);
            tx.tx_valid = 1'b0;
            repeat (HALF - 2) @(negedge CLOCK_50);
         end else begin
            repeat (HALF) @(negedge CLOCK_50);
         end
         dev_clk_low = 1'b0;
         if (i == 11) dev_dat_low = 1'b0;
         repeat (HALF / 2) @(negedge CLOCK_50);
         if (i <= 10) cap[i-1] = pin_dat;
         if (i == 10 && ack) dev_dat_low = 1'b1;
         repeat (HALF - HALF / 2) @(negedge CLOCK_50);
      end
      dev_dat_low = 1'b0;
      if (aborted) begin
         repeat (5) @(negedge CLOCK_50);
         check("rst_no_pulse", 32'((done_cnt - d0) + (err_cnt - e0)), 32'd0);
      end else begin
         repeat (10) @(negedge CLOCK_50);
         check("frame", 32'(cap), 32'(model_frame(b)));
         check("done_cnt", 32'(done_cnt - d0), 32'(ack));
         check("err_cnt", 32'(err_cnt - e0), 32'(!ack));
         if (!ack) check("err_lines", 32'(err_snap), 32'd0);
         check("ready_after", 32'(tx.tx_ready), 32'(exp_ready));
         if (exp_ready) check("idle_lines", 32'({ps2_clk_oe, ps2_dat_oe, tx.busy}), 32'd0);
      end
   endtask

   initial begin
      int n;
      tx.tx_data  = 8'h00;
      tx.tx_valid = 1'b0;
      reset = 1'b1;
      repeat (5) @(negedge CLOCK_50);
      check("reset_outs", 32'({tx.tx_ready, tx.tx_done, tx.tx_error, tx.busy, ps2_clk_oe, ps2_dat_oe}), 32'd0);
      reset = 1'b0;
      @(posedge CLOCK_50);
      #1;
`ifdef PS2_TX_AUTOINIT_EN
      check("auto_ready_low", 32'(tx.tx_ready), 32'd0);
      @(negedge CLOCK_50);
      run_frame(CMD_ENABLE, 1'b1, 1'b1, 1'b1, 0, 1'b0);
`else
      check("ready_rise", 32'(tx.tx_ready), 32'd1);
`endif

      start_byte(CMD_ENABLE);
      run_frame(CMD_ENABLE, 1'b1, 1'b1, 1'b1, 0, 1'b0);

      start_byte(8'h00);
      run_frame(8'h00, 1'b1, 1'b1, 1'b1, 0, 1'b0);

      start_byte(8'h81);
      run_frame(8'h81, 1'b0, 1'b1, 1'b1, 0, 1'b0);

      start_byte(CMD_DEFAULTS);
      n = 0;
      while (ps2_clk_oe && n < INH + 100) begin
         n++;
         @(negedge CLOCK_50);
      end
      n = 0;
      while (!tx.tx_error && n < TMO + 100) begin
         @(negedge CLOCK_50);
         n++;
      end
      check("timeout_len", 32'(n), 32'(TMO));
      check("timeout_lines", 32'({ps2_clk_oe, ps2_dat_oe, tx.busy, tx.tx_done}), 32'd0);
      @(negedge CLOCK_50);

      start_byte(8'h37);
      run_frame(8'h37, 1'b1, 1'b1, 1'b1, 5, 1'b0);
      start_byte(CMD_RESET);
      run_frame(CMD_RESET, 1'b1, 1'b1, 1'b1, 0, 1'b0);

      start_byte(8'hC3);
      run_frame(8'hC3, 1'b1, 1'b1, 1'b1, 0, 1'b1);
      repeat (50) @(negedge CLOCK_50);
      check("no_queue", 32'({ps2_clk_oe, tx.busy}), 32'd0);

      for (int k = 0; k < 5; k++) begin
         logic [7:0] rb;
         bit         ra;
         rb = 8'($urandom);
         ra = ($urandom_range(0, 3) != 0);
         start_byte(rb);
         run_frame(rb, ra, 1'b1, 1'b1, 0, 1'b0);
      end

`ifdef PS2_TX_AUTOINIT_EN
      reset = 1'b1;
      repeat (3) @(negedge CLOCK_50);
      reset = 1'b0;
      @(negedge CLOCK_50);
      run_frame(CMD_ENABLE, 1'b0, 1'b1, 1'b0, 0, 1'b0);
      run_frame(CMD_ENABLE, 1'b0, 1'b0, 1'b0, 0, 1'b0);
      run_frame(CMD_ENABLE, 1'b0, 1'b0, 1'b1, 0, 1'b0);
`endif

      check("done_error_overlap", 32'(overlap), 32'd0);
      check("done_width", 32'(wide), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
